// File: rtl/forward_transform.sv
// rtl/forward_transform.sv - 4x4/8x8 HEVC integer forward DCT, row pass then column pass.
// One dot product per cycle; samples and row results live in stride-8 buffers.
module forward_transform #(
  parameter int RES_WIDTH   = 9,
  parameter int COEFF_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_size,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [RES_WIDTH-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [COEFF_WIDTH-1:0] out_data,
  output logic                          out_last,
  output logic                          busy
);

  typedef enum logic [1:0] {IDLE, LOAD, ROW, COL} state_t;

  state_t            state_q, state_d;
  logic              size8_q, size8_d;
  logic [6:0]        cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic signed [15:0] y_q, y_d;

  logic signed [RES_WIDTH-1:0] x_q   [64];
  logic signed [15:0]          tmp_q [64];

  logic              sz;
  logic [2:0]        idx_hi, idx_lo, trow, tsel;
  logic [5:0]        addr;
  logic [6:0]        last_idx;
  logic              in_fire, out_load, x_we, tmp_we;
  logic [3:0]        sh;
  logic signed [31:0] acc, opnd, rounded;
  logic signed [15:0] satv;

  // Row k of the 8-point core matrix, column c packed at the LSB end.
  function automatic logic signed [7:0] tcoef(input logic [2:0] k, input logic [2:0] c);
    logic [63:0] row;
    case (k)
      3'd0:    row = {8'sd64, 8'sd64, 8'sd64, 8'sd64, 8'sd64, 8'sd64, 8'sd64, 8'sd64};
      3'd1:    row = {-8'sd89, -8'sd75, -8'sd50, -8'sd18, 8'sd18, 8'sd50, 8'sd75, 8'sd89};
      3'd2:    row = {8'sd83, 8'sd36, -8'sd36, -8'sd83, -8'sd83, -8'sd36, 8'sd36, 8'sd83};
      3'd3:    row = {-8'sd75, 8'sd18, 8'sd89, 8'sd50, -8'sd50, -8'sd89, -8'sd18, 8'sd75};
      3'd4:    row = {8'sd64, -8'sd64, -8'sd64, 8'sd64, 8'sd64, -8'sd64, -8'sd64, 8'sd64};
      3'd5:    row = {-8'sd50, 8'sd89, -8'sd18, -8'sd75, 8'sd75, 8'sd18, -8'sd89, 8'sd50};
      3'd6:    row = {8'sd36, -8'sd83, 8'sd83, -8'sd36, -8'sd36, 8'sd83, -8'sd83, 8'sd36};
      default: row = {-8'sd18, 8'sd50, -8'sd75, 8'sd89, -8'sd89, 8'sd75, -8'sd50, 8'sd18};
    endcase
    return row[{c, 3'b000} +: 8];
  endfunction

  // In IDLE the block size is not latched yet; the live cfg_size decides.
  assign sz       = (state_q == IDLE) ? cfg_size : size8_q;
  assign idx_hi   = sz ? cnt_q[5:3] : {1'b0, cnt_q[3:2]};
  assign idx_lo   = sz ? cnt_q[2:0] : {1'b0, cnt_q[1:0]};
  assign addr     = {idx_hi, idx_lo};
  assign last_idx = size8_q ? 7'd63 : 7'd15;

  assign in_ready  = !reset && (state_q == IDLE || state_q == LOAD);
  assign in_fire   = in_ready && in_valid;
  assign out_load  = !out_valid_q || out_ready;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = COEFF_WIDTH'(y_q);
  assign busy      = (state_q != IDLE);

  always_comb begin
    trow = (state_q == COL) ? idx_hi : idx_lo;
    tsel = size8_q ? trow : {trow[1:0], 1'b0};
    acc  = '0;
    opnd = '0;
    for (int j = 0; j < 8; j++) begin
      if (size8_q || j < 4) begin
        if (state_q == COL) opnd = 32'(tmp_q[{j[2:0], idx_lo}]);
        else                opnd = 32'(x_q[{idx_hi, j[2:0]}]);
        acc = acc + 32'(tcoef(tsel, j[2:0])) * opnd;
      end
    end
    if (state_q == COL) sh = size8_q ? 4'd9 : 4'd8;
    else                sh = size8_q ? 4'd2 : 4'd1;
    rounded = (acc + (32'sd1 <<< (sh - 4'd1))) >>> sh;
    if (rounded > 32'sd32767)       satv = 16'sh7fff;
    else if (rounded < -32'sd32768) satv = 16'sh8000;
    else                            satv = rounded[15:0];
  end

  always_comb begin
    state_d     = state_q;
    size8_d     = size8_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    y_d         = y_q;
    x_we        = 1'b0;
    tmp_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          size8_d = cfg_size;
          x_we    = 1'b1;
          cnt_d   = 7'd1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (in_fire) begin
          x_we = 1'b1;
          if (cnt_q == last_idx) begin
            cnt_d   = '0;
            state_d = ROW;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      ROW: begin
        tmp_we = 1'b1;
        if (cnt_q == last_idx) begin
          cnt_d   = '0;
          state_d = COL;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      default: begin
        // cnt_q == N*N means every coefficient is out and the last one is being taken.
        if (out_load) begin
          if (cnt_q != last_idx + 7'd1) begin
            y_d         = satv;
            out_valid_d = 1'b1;
            out_last_d  = (cnt_q == last_idx);
            cnt_d       = cnt_q + 7'd1;
          end else begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            cnt_d       = '0;
            state_d     = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      size8_q     <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      y_q         <= '0;
    end else begin
      state_q     <= state_d;
      size8_q     <= size8_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      y_q         <= y_d;
    end
  end

  always_ff @(posedge clk) begin
    if (x_we)   x_q[addr]   <= in_data;
    if (tmp_we) tmp_q[addr] <= satv;
  end

endmodule

// File: tb/tb_forward_transform.sv
// tb/tb_forward_transform.sv - directed and reference-model checks for forward_transform.
module tb_forward_transform;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_size = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [8:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic signed [15:0] out_data;
  logic              out_last;
  logic              busy;

  always #5 clk = ~clk;

  forward_transform #(.RES_WIDTH(9), .COEFF_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .cfg_size(cfg_size),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int t8 [8][8];
  int xin  [64];
  int yexp [64];
  int yout [64];
  int yref [64];
  int nout, nlast, lat, total_last;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int tc(input int n, input int k, input int c);
    return (n == 8) ? t8[k][c] : t8[2*k][c];
  endfunction

  task automatic model(input int n);
    longint tmp [8][8];
    longint acc;
    int s1, s2;
    s1 = (n == 8) ? 2 : 1;
    s2 = (n == 8) ? 9 : 8;
    for (int r = 0; r < n; r++)
      for (int k = 0; k < n; k++) begin
        acc = 0;
        for (int c = 0; c < n; c++) acc += longint'(tc(n, k, c)) * xin[r*n+c];
        tmp[r][k] = sat16((acc + (64'sd1 <<< (s1-1))) >>> s1);
      end
    for (int u = 0; u < n; u++)
      for (int v = 0; v < n; v++) begin
        acc = 0;
        for (int r = 0; r < n; r++) acc += longint'(tc(n, u, r)) * tmp[r][v];
        yexp[u*n+v] = int'(sat16((acc + (64'sd1 <<< (s2-1))) >>> s2));
      end
  endtask

  // mode 0: out_ready=1, 1: random out_ready, 2: out_ready=0.
  // cfg_size is inverted after the first sample to prove it is latched.
  task automatic run_block(input bit sz, input int mode, input bit stop_on_valid,
                           output int no, output int nl, output int lt);
    int nn, idx, cyc, t_in;
    bit done, stall;
    logic signed [15:0] held_d;
    logic held_l;
    nn = sz ? 64 : 16;
    idx = 0; cyc = 0; t_in = -1; done = 0; stall = 0;
    held_d = '0; held_l = 1'b0;
    no = 0; nl = 0; lt = -1;
    while (!done && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      in_valid  = 1'b1;
      in_data   = (idx < nn) ? 9'(xin[idx]) : 9'h0aa;
      cfg_size  = (idx == 0) ? sz : !sz;
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, held_d);
        check("stall_last", out_last, held_l);
      end
      if (in_ready) begin
        if (idx < nn) begin
          idx++;
          if (idx == nn) t_in = cyc;
        end else begin
          check("extra_accept", in_ready, 0);
        end
      end
      if (out_valid && lt < 0) lt = cyc - t_in;
      if (stop_on_valid && out_valid) done = 1;
      stall  = out_valid && !out_ready;
      held_d = out_data;
      held_l = out_last;
      if (out_valid && out_ready) begin
        if (no < 64) yout[no] = out_data;
        check("last_flag", out_last, (no == nn - 1));
        no++;
        if (out_last) begin
          nl++;
          done = 1;
        end
      end
    end
    if (!done) check("timeout", cyc, -1);
    if (!stop_on_valid) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("idle_in_ready", in_ready, 1);
      check("idle_out_valid", out_valid, 0);
      check("idle_busy", busy, 0);
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < 64; i++) xin[i] = (i < n*n) ? int'($urandom_range(0, 511)) - 256 : 0;
  endtask

  task automatic cmp_model(input string tag, input int n);
    model(n);
    for (int i = 0; i < n*n; i++) check(tag, yout[i], yexp[i]);
  endtask

  initial begin
    t8 = '{'{64, 64, 64, 64, 64, 64, 64, 64},
           '{89, 75, 50, 18, -18, -50, -75, -89},
           '{83, 36, -36, -83, -83, -36, 36, 83},
           '{75, -18, -89, -50, 50, 89, 18, -75},
           '{64, -64, -64, 64, 64, -64, -64, 64},
           '{50, -89, 18, 75, -75, -18, 89, -50},
           '{36, -83, 83, -36, -36, 83, -83, 36},
           '{18, -50, 75, -89, 89, -75, 50, -18}};

    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // 4x4 DC
    for (int i = 0; i < 64; i++) xin[i] = 1;
    run_block(0, 0, 0, nout, nlast, lat);
    check("dc4_count", nout, 16);
    check("dc4_lat", lat, 18);
    for (int i = 0; i < 16; i++) check("dc4_y", yout[i], (i == 0) ? 128 : 0);

    // 8x8 DC
    run_block(1, 0, 0, nout, nlast, lat);
    check("dc8_count", nout, 64);
    check("dc8_lat", lat, 66);
    for (int i = 0; i < 64; i++) check("dc8_y", yout[i], (i == 0) ? 128 : 0);

    // 8x8 negative full scale saturates at the bottom of the range
    for (int i = 0; i < 64; i++) xin[i] = -256;
    run_block(1, 0, 0, nout, nlast, lat);
    for (int i = 0; i < 64; i++) check("neg8_y", yout[i], (i == 0) ? -32768 : 0);

    // 4x4 impulse
    for (int i = 0; i < 64; i++) xin[i] = 0;
    xin[0] = 64;
    run_block(0, 0, 0, nout, nlast, lat);
    check("imp_y00", yout[0], 512);
    check("imp_y01", yout[1], 664);
    check("imp_y02", yout[2], 512);
    check("imp_y03", yout[3], 288);
    check("imp_y11", yout[5], 861);
    cmp_model("imp_model", 4);

    // random 8x8 with and without backpressure
    for (int b = 0; b < 2; b++) begin
      fill_random(8);
      run_block(1, 0, 0, nout, nlast, lat);
      for (int i = 0; i < 64; i++) yref[i] = yout[i];
      cmp_model("rnd8_model", 8);
      run_block(1, 1, 0, nout, nlast, lat);
      check("rnd8_bp_count", nout, 64);
      for (int i = 0; i < 64; i++) check("rnd8_bp_seq", yout[i], yref[i]);
    end

    // reset while coefficients are pending
    fill_random(4);
    run_block(0, 2, 1, nout, nlast, lat);
    check("abort_in_col", out_valid, 1);
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_rel_in_ready", in_ready, 1);
    fill_random(4);
    run_block(0, 0, 0, nout, nlast, lat);
    cmp_model("after_abort", 4);

    // back-to-back mixed sizes
    total_last = 0;
    fill_random(8);
    run_block(1, 1, 0, nout, nlast, lat);
    total_last += nlast;
    check("b2b_a_count", nout, 64);
    cmp_model("b2b_a", 8);
    fill_random(4);
    run_block(0, 0, 0, nout, nlast, lat);
    total_last += nlast;
    check("b2b_b_count", nout, 16);
    cmp_model("b2b_b", 4);
    fill_random(8);
    run_block(1, 0, 0, nout, nlast, lat);
    total_last += nlast;
    check("b2b_c_count", nout, 64);
    cmp_model("b2b_c", 8);
    check("b2b_last_total", total_last, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/forward_transform.md
FORWARD_TRANSFORM -- requirements
Module: forward_transform

Interface
REQ-001 SHALL have parameter RES_WIDTH, default 9, signed residual sample width.
REQ-002 SHALL have parameter COEFF_WIDTH, default 16, signed output coefficient width.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cfg_size  input  1  block size: 0 = 4x4, 1 = 8x8.
REQ-006 SHALL have port in_valid  input  1  residual sample valid.
REQ-007 SHALL have port in_ready  output  1  block accepts a sample.
REQ-008 SHALL have port in_data  input  RES_WIDTH  signed residual, row-major X[r][c].
REQ-009 SHALL have port out_valid  output  1  coefficient valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts a coefficient.
REQ-011 SHALL have port out_data  output  COEFF_WIDTH  signed coefficient, row-major Y[u][v].
REQ-012 SHALL have port out_last  output  1  high with the final coefficient of a block.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL use states IDLE, LOAD, ROW, COL.
- A transfer occurs on any cycle where valid and ready are both high.
REQ-015 SHALL drive in_ready high only in IDLE and LOAD, and drive it low in ROW and COL.
REQ-016 SHALL, on the first input transfer in IDLE, latch cfg_size as N (4 or 8) for the whole block, store the sample as X[0][0], and go to LOAD.
- cfg_size is ignored at all other times.
REQ-017 SHALL store samples in row-major order during LOAD, and go to ROW on the cycle after the N*N-th transfer.
REQ-018 SHALL use T, the HEVC 8x8 integer DCT-II core matrix, as the transform matrix.
- The 4x4 matrix is rows 0, 2, 4, 6 of T, columns 0-3.
REQ-019 SHALL, in ROW, compute one element per cycle, N*N cycles total, in row-major order of (r, k): tmp[r][k] = sat16((sum_c T[k][c]*X[r][c] + (1<<(s1-1))) >>> s1).
- s1 = 1 for N=4, 2 for N=8.
REQ-020 SHALL, in COL, compute Y[u][v] = sat16((sum_r T[u][r]*tmp[r][v] + (1<<(s2-1))) >>> s2), in row-major order of (u, v).
- s2 = 8 for N=4, 9 for N=8.
REQ-021 SHALL use signed accumulators of at least 27 bits, use arithmetic right shift (floor), and saturate to [-32768, 32767].
REQ-022 SHALL present each Y through an output register.
- The next Y is loaded only when out_valid is low, or when out_valid and out_ready are both high (one coefficient per cycle at full throughput).
REQ-023 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-024 SHALL assert out_last only with Y[N-1][N-1].
REQ-025 SHALL, on the out_last transfer, drop out_valid and return to IDLE on the next cycle; in_ready=1 on that cycle.
REQ-026 SHALL treat in_valid as don't-care in ROW and COL; no sample is consumed.
REQ-027 SHALL give a minimum block latency of N*N ROW cycles plus 1 cycle from the last input transfer to the first out_valid, with out_ready held high.
REQ-028 SHALL allow a new block to use a different cfg_size with no restriction.

Reset
REQ-029 SHALL, while reset=1, force state IDLE, in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0.
REQ-030 SHALL drive in_ready=1 on the first cycle after reset deasserts.
REQ-031 SHALL, on reset asserted in any state, abort the block, discard all buffered samples and partial results, and emit no further coefficients.

Verification
REQ-032 SHALL cover a 4x4 block with all X=1 and out_ready=1: Y[0][0]=128, the other 15 coefficients 0, out_last on the 16th.
REQ-033 SHALL cover an 8x8 block with all X=1: Y[0][0]=128, the other 63 coefficients 0. It SHALL also cover an 8x8 block with all X=-256: Y[0][0]=-32768, the others 0.
REQ-034 SHALL cover a 4x4 impulse X[0][0]=64, others 0: row 0 of Y is 512, 664, 512, 288, and Y[1][1]=861.
REQ-035 SHALL cover random 8x8 blocks with out_ready toggled pseudo-randomly: the output sequence is identical to the out_ready=1 run, and out_data is stable during every stall.
REQ-036 SHALL cover reset asserted mid-COL: out_valid=0 immediately, in_ready=1 after release, and the next 4x4 block is correct.
REQ-037 SHALL cover back-to-back blocks (8x8, then 4x4, then 8x8) with cfg_size changed mid-LOAD: each block uses its latched size, and out_last count = 3.
